mips_lsu: RTL

MIPS_LSU -- requirements
Module: mips_lsu

---
 rtl/mips_lsu_pkg.sv | 33 +++
 rtl/mips_lsu_lane.sv | 63 ++++++
 rtl/mips_lsu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared types and constants for the MIPS load/store unit.
package mips_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        FAULT = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_ADES = 5'd5;
    localparam logic [4:0] CAUSE_DBE  = 5'd7;

    // An access is misaligned when its low address bits do not fit the size;
    // the reserved size encoding is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Byte-lane steering: store write mask and replication, load extract and extend.
module mips_lsu_lane
    import mips_lsu_pkg::*;
#(
    parameter int LITTLE_END = 1
) (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wlanes,
    output logic [31:0] rdata
);

    logic [3:0]  mask_le_s;
    logic [1:0]  off_s;
    logic [31:0] shifted_s;

    // Mask, replicated store data and the lane offset of the addressed item.
    always_comb begin
        mask_le_s = 4'b0000;
        wlanes    = 32'h0000_0000;
        off_s     = 2'd0;
        case (size)
            SIZE_BYTE: begin
                mask_le_s = 4'b0001 << addr_lo;
                wlanes    = {4{wdata[7:0]}};
                off_s     = (LITTLE_END != 0) ? addr_lo : (2'd3 - addr_lo);
            end
            SIZE_HALF: begin
                mask_le_s = 4'b0011 << addr_lo;
                wlanes    = {2{wdata[15:0]}};
                off_s     = (LITTLE_END != 0) ? addr_lo : (2'd2 - addr_lo);
            end
            SIZE_WORD: begin
                mask_le_s = 4'b1111;
                wlanes    = wdata;
                off_s     = 2'd0;
            end
            default: begin
                mask_le_s = 4'b0000;
                wlanes    = 32'h0000_0000;
                off_s     = 2'd0;
            end
        endcase
        // Big-endian places byte 0 in the most significant lane.
        wmask = (LITTLE_END != 0) ? mask_le_s
                                  : {mask_le_s[0], mask_le_s[1], mask_le_s[2], mask_le_s[3]};
    end

    // Right-justify the addressed lane(s) of the load word and extend.
    always_comb begin
        shifted_s = rword >> {off_s, 3'b000};
        case (size)
            SIZE_BYTE: rdata = {{24{is_signed & shifted_s[7]}}, shifted_s[7:0]};
            SIZE_HALF: rdata = {{16{is_signed & shifted_s[15]}}, shifted_s[15:0]};
            default:   rdata = rword;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: accepts one core access, aligns it, runs the memory
// handshake with a bounded wait, and returns a one-cycle response.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int LITTLE_END = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_excpt,
    output logic [4:0]  resp_cause,
    output logic [31:0] resp_bva,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_write_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_data_out,
    input  logic        mem_excpt
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d, write_q, write_d;

    logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
    logic        resp_excpt_q, resp_excpt_d, mem_req_q, mem_req_d;
    logic [31:0] resp_rdata_q, resp_rdata_d, resp_bva_q, resp_bva_d;
    logic [4:0]  resp_cause_q, resp_cause_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic [3:0]  mem_write_en_q, mem_write_en_d;

    logic [3:0]  lane_mask_s;
    logic [31:0] lane_wdata_s, lane_rdata_s;

    // Fields are stable through REQ, so one lane instance serves both the
    // store path (at acceptance) and the load path (at the ack edge).
    mips_lsu_lane #(.LITTLE_END(LITTLE_END)) u_lane (
        .addr_lo   (addr_d[1:0]),
        .size      (size_d),
        .is_signed (signed_d),
        .wdata     (wdata_d),
        .rword     (mem_data_out),
        .wmask     (lane_mask_s),
        .wlanes    (lane_wdata_s),
        .rdata     (lane_rdata_s)
    );

    // Next state, request capture, and outputs registered from the next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    cnt_d    = {CW{1'b0}};
                    state_d  = is_misaligned(req_size, req_addr[1:0]) ? FAULT : REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // An ack in the timeout cycle still completes normally.
                if (mem_ack) begin
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d    = 1'b0;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = 32'h0000_0000;
        resp_excpt_d   = 1'b0;
        resp_cause_d   = 5'd0;
        resp_bva_d     = 32'h0000_0000;
        mem_req_d      = 1'b0;
        mem_addr_d     = 30'h0000_0000;
        mem_data_in_d  = 32'h0000_0000;
        mem_write_en_d = 4'b0000;

        case (state_d)
            IDLE: req_ready_d = 1'b1;
            REQ: begin
                mem_req_d      = 1'b1;
                mem_addr_d     = addr_d[31:2];
                mem_write_en_d = write_d ? lane_mask_s : 4'b0000;
                mem_data_in_d  = write_d ? lane_wdata_s : 32'h0000_0000;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                resp_excpt_d = mem_excpt;
                resp_cause_d = mem_excpt ? CAUSE_DBE : 5'd0;
                resp_bva_d   = mem_excpt ? addr_d : 32'h0000_0000;
                resp_rdata_d = (mem_excpt || write_d) ? 32'h0000_0000 : lane_rdata_s;
            end
            FAULT: begin
                resp_valid_d = 1'b1;
                resp_excpt_d = 1'b1;
                resp_bva_d   = addr_d;
                resp_cause_d = (state_q == REQ) ? CAUSE_DBE
                             : (write_d ? CAUSE_ADES : CAUSE_ADEL);
            end
            default: req_ready_d = 1'b0;
        endcase
    end

    // State, counter, request fields and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= IDLE;
            cnt_q          <= {CW{1'b0}};
            addr_q         <= 32'h0000_0000;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            write_q        <= 1'b0;
            wdata_q        <= 32'h0000_0000;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0000_0000;
            resp_excpt_q   <= 1'b0;
            resp_cause_q   <= 5'd0;
            resp_bva_q     <= 32'h0000_0000;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 30'h0000_0000;
            mem_data_in_q  <= 32'h0000_0000;
            mem_write_en_q <= 4'b0000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            write_q        <= write_d;
            wdata_q        <= wdata_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_excpt_q   <= resp_excpt_d;
            resp_cause_q   <= resp_cause_d;
            resp_bva_q     <= resp_bva_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_write_en_q <= mem_write_en_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_excpt   = resp_excpt_q;
    assign resp_cause   = resp_cause_q;
    assign resp_bva     = resp_bva_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_in  = mem_data_in_q;
    assign mem_write_en = mem_write_en_q;

endmodule
